// File: rtl/endian_mem_ctrl.sv
// endian_mem_ctrl: byte-addressable data memory with configurable word width,
// depth and byte order. Storage is one byte-wide bank per lane, all banks
// sharing one word index. Accesses that straddle a word boundary take two
// cycles: the first word in IDLE, the remainder in SPLIT.
//
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   req, we         request strobe (accepted when req && ready) and write flag
//   addr            byte address of the first byte of the access
//   size            access size, 2**size bytes
//   wdata           right-justified write data
//   ready           block can accept a request this cycle
//   rvalid, rdata   one-cycle read-data pulse; rdata right-justified, zero-extended
//   err             one-cycle pulse for an access wider than a word
module endian_mem_ctrl #(
    parameter int unsigned WORD_BYTES  = 4,
    parameter int unsigned WORD_ADDR_W = 16,
    parameter bit          BIG_ENDIAN  = 1'b1
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      req,
    input  logic                                      we,
    input  logic [WORD_ADDR_W+$clog2(WORD_BYTES)-1:0] addr,
    input  logic [1:0]                                size,
    input  logic [8*WORD_BYTES-1:0]                   wdata,
    output logic                                      ready,
    output logic                                      rvalid,
    output logic [8*WORD_BYTES-1:0]                   rdata,
    output logic                                      err
);

    localparam int unsigned DW    = 8 * WORD_BYTES;
    localparam int unsigned OFF_W = $clog2(WORD_BYTES);
    localparam int unsigned BA_W  = WORD_ADDR_W + OFF_W;
    localparam int unsigned DEPTH = 2 ** WORD_ADDR_W;
    localparam int unsigned CNT_W = OFF_W + 1;
    localparam int          WB    = int'(WORD_BYTES);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SPLIT = 1'b1
    } state_t;

    state_t state;
    state_t state_next;

    // One bank per byte lane
    logic [7:0] mem [WORD_BYTES][DEPTH];

    logic [OFF_W-1:0]              off;
    logic [WORD_ADDR_W-1:0]        word;
    logic [WORD_ADDR_W-1:0]        acc_word;
    logic [WORD_BYTES-1:0][7:0]    rd_lane;
    logic [WORD_BYTES-1:0][7:0]    wr_byte;
    logic [WORD_BYTES-1:0]         wr_en;

    // Split-access context: second-half write bytes in bank order and
    // first-half read bytes in access order
    logic                          sp_we,      sp_we_n;
    logic [CNT_W-1:0]              sp_first,   sp_first_n;
    logic [CNT_W-1:0]              sp_rem,     sp_rem_n;
    logic [WORD_ADDR_W-1:0]        sp_word,    sp_word_n;
    logic [WORD_BYTES-1:0][7:0]    sp_wbytes,  sp_wbytes_n;
    logic [WORD_BYTES-1:0][7:0]    cap,        cap_n;

    logic                          rvalid_n;
    logic                          err_n;
    logic [DW-1:0]                 rdata_n;

    // Place access-ordered bytes into a right-justified word per byte order
    function automatic logic [DW-1:0] pack_bytes(input logic [WORD_BYTES-1:0][7:0] bytes,
                                                 input int n);
        logic [DW-1:0] r;
        int            pos;
        r = '0;
        for (int k = 0; k < WB; k++) begin
            if (k < n) begin
                pos = BIG_ENDIAN ? (n - 1 - k) : k;
                r   = r | (DW'(bytes[k]) << (8 * pos));
            end
        end
        return r;
    endfunction

    assign off  = addr[OFF_W-1:0];
    assign word = addr[BA_W-1:OFF_W];

    // Word index driven to all banks this cycle
    always_comb begin : access_word
        acc_word = (state == SPLIT) ? sp_word : word;
    end

    // Asynchronous bank read so a write in the previous cycle is visible
    always_comb begin : bank_read
        for (int b = 0; b < WB; b++) begin
            rd_lane[b] = mem[b][acc_word];
        end
    end

    // Next-state, bank write enables and registered-output next values
    always_comb begin : next_logic
        int n_i;
        int off_i;
        int first_i;
        int rem_i;
        int k;
        logic [WORD_BYTES-1:0][7:0] wbytes;
        logic [WORD_BYTES-1:0][7:0] acc_bytes;

        state_next  = state;
        rvalid_n    = 1'b0;
        err_n       = 1'b0;
        rdata_n     = rdata;
        wr_en       = '0;
        wr_byte     = '0;
        sp_we_n     = sp_we;
        sp_first_n  = sp_first;
        sp_rem_n    = sp_rem;
        sp_word_n   = sp_word;
        sp_wbytes_n = sp_wbytes;
        cap_n       = cap;
        n_i         = 1 << int'(size);
        off_i       = int'(off);
        first_i     = 0;
        rem_i       = 0;
        k           = 0;
        wbytes      = '0;
        acc_bytes   = '0;

        case (state)
            IDLE: begin
                // Write bytes in access order
                for (int i = 0; i < WB; i++) begin
                    if (i < n_i) begin
                        wbytes[i] = 8'(wdata >> (8 * (BIG_ENDIAN ? (n_i - 1 - i) : i)));
                    end
                end
                if (req) begin
                    if (n_i > WB) begin
                        err_n = 1'b1;
                    end else begin
                        // Lanes of the first (or only) word touched by the access
                        for (int b = 0; b < WB; b++) begin
                            k = b - off_i;
                            if (k >= 0 && k < n_i) begin
                                wr_en[b]                = we;
                                wr_byte[b]              = wbytes[OFF_W'(k)];
                                acc_bytes[OFF_W'(k)]    = rd_lane[b];
                            end
                        end
                        if (off_i + n_i > WB) begin
                            first_i    = WB - off_i;
                            rem_i      = n_i - first_i;
                            state_next = SPLIT;
                            sp_we_n    = we;
                            sp_first_n = CNT_W'(first_i);
                            sp_rem_n   = CNT_W'(rem_i);
                            // Wraps past the top word to word 0
                            sp_word_n  = word + WORD_ADDR_W'(1);
                            for (int j = 0; j < WB; j++) begin
                                sp_wbytes_n[j] = (j < rem_i) ? wbytes[OFF_W'(first_i + j)] : 8'h00;
                            end
                            cap_n = acc_bytes;
                        end else if (!we) begin
                            rvalid_n = 1'b1;
                            rdata_n  = pack_bytes(acc_bytes, n_i);
                        end
                    end
                end
            end

            SPLIT: begin
                // Remainder always starts at bank 0 of the next word
                first_i   = int'(sp_first);
                rem_i     = int'(sp_rem);
                acc_bytes = cap;
                for (int b = 0; b < WB; b++) begin
                    if (b < rem_i) begin
                        wr_en[b]                         = sp_we;
                        wr_byte[b]                       = sp_wbytes[b];
                        acc_bytes[OFF_W'(first_i + b)]   = rd_lane[b];
                    end
                end
                if (!sp_we) begin
                    rvalid_n = 1'b1;
                    rdata_n  = pack_bytes(acc_bytes, first_i + rem_i);
                end
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // FSM state and registered outputs
    always_ff @(posedge clk) begin : ctrl_regs
        if (rst) begin
            state  <= IDLE;
            ready  <= 1'b1;
            rvalid <= 1'b0;
            rdata  <= '0;
            err    <= 1'b0;
        end else begin
            state  <= state_next;
            ready  <= (state_next == IDLE);
            rvalid <= rvalid_n;
            rdata  <= rdata_n;
            err    <= err_n;
        end
    end

    // Split context carries data only; it is qualified by state
    always_ff @(posedge clk) begin : ctx_regs
        sp_we     <= sp_we_n;
        sp_first  <= sp_first_n;
        sp_rem    <= sp_rem_n;
        sp_word   <= sp_word_n;
        sp_wbytes <= sp_wbytes_n;
        cap       <= cap_n;
    end

    // Bank writes; reset suppresses any write in the same cycle
    always_ff @(posedge clk) begin : bank_write
        for (int b = 0; b < WB; b++) begin
            if (!rst && wr_en[b]) begin
                mem[b][acc_word] <= wr_byte[b];
            end
        end
    end

endmodule

// File: tb/tb_endian_mem_ctrl.sv
module tb_endian_mem_ctrl;

    logic        clk;
    logic        rst;
    logic        req;
    logic        we;
    logic [5:0]  addr;
    logic [1:0]  size;
    logic [31:0] wdata;

    logic        ready_be, rvalid_be, err_be;
    logic [31:0] rdata_be;
    logic        ready_le, rvalid_le, err_le;
    logic [31:0] rdata_le;

    int checks;
    int errors;
    bit chk_en;

    endian_mem_ctrl #(.WORD_BYTES(4), .WORD_ADDR_W(4), .BIG_ENDIAN(1'b1)) dut_be (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .size(size), .wdata(wdata),
        .ready(ready_be), .rvalid(rvalid_be), .rdata(rdata_be), .err(err_be)
    );

    endian_mem_ctrl #(.WORD_BYTES(4), .WORD_ADDR_W(4), .BIG_ENDIAN(1'b0)) dut_le (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .size(size), .wdata(wdata),
        .ready(ready_le), .rvalid(rvalid_le), .rdata(rdata_le), .err(err_le)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Reference model: 64-byte memory images for each byte order
    logic [7:0]  m_be [64];
    logic [7:0]  m_le [64];
    logic        e_ready, e_rvalid, e_err;
    logic [31:0] e_rd_be, e_rd_le;
    bit          p_on, p_rd;
    int          p_n;
    int          p_a  [4];
    logic [7:0]  p_be [4];
    logic [7:0]  p_le [4];
    logic [31:0] p_vbe, p_vle;
    int          m_n, m_a;
    logic [7:0]  db, dl;
    logic [31:0] v_be, v_le;

    always @(posedge clk) begin : model
        if (rst) begin
            e_ready = 1'b1; e_rvalid = 1'b0; e_err = 1'b0;
            e_rd_be = 32'h0; e_rd_le = 32'h0; p_on = 1'b0;
        end else begin
            e_rvalid = 1'b0;
            e_err    = 1'b0;
            if (p_on) begin
                for (int j = 0; j < p_n; j++) begin
                    m_be[p_a[j]] = p_be[j];
                    m_le[p_a[j]] = p_le[j];
                end
                if (p_rd) begin
                    e_rvalid = 1'b1; e_rd_be = p_vbe; e_rd_le = p_vle;
                end
                p_on = 1'b0;
                e_ready = 1'b1;
            end else if (req) begin
                m_n = 1 << int'(size);
                if (m_n > 4) begin
                    e_err = 1'b1;
                end else begin
                    v_be = 32'h0; v_le = 32'h0; p_n = 0;
                    for (int k = 0; k < m_n; k++) begin
                        m_a = (int'(addr) + k) % 64;
                        db  = 8'(wdata >> (8 * (m_n - 1 - k)));
                        dl  = 8'(wdata >> (8 * k));
                        if (we) begin
                            if ((int'(addr) % 4) + k < 4) begin
                                m_be[m_a] = db; m_le[m_a] = dl;
                            end else begin
                                p_a[p_n] = m_a; p_be[p_n] = db; p_le[p_n] = dl; p_n++;
                            end
                        end else begin
                            v_be = v_be | (32'(m_be[m_a]) << (8 * (m_n - 1 - k)));
                            v_le = v_le | (32'(m_le[m_a]) << (8 * k));
                        end
                    end
                    if ((int'(addr) % 4) + m_n > 4) begin
                        p_on = 1'b1; p_rd = !we; p_vbe = v_be; p_vle = v_le; e_ready = 1'b0;
                    end else if (!we) begin
                        e_rvalid = 1'b1; e_rd_be = v_be; e_rd_le = v_le;
                    end
                end
            end
        end
    end

    // Every-cycle comparison of both DUTs against the model
    always @(negedge clk) begin : compare
        if (chk_en) begin
            chk("ready_be",  32'(ready_be),  32'(e_ready));
            chk("ready_le",  32'(ready_le),  32'(e_ready));
            chk("rvalid_be", 32'(rvalid_be), 32'(e_rvalid));
            chk("rvalid_le", 32'(rvalid_le), 32'(e_rvalid));
            chk("err_be",    32'(err_be),    32'(e_err));
            chk("err_le",    32'(err_le),    32'(e_err));
            chk("rdata_be",  rdata_be,       e_rd_be);
            chk("rdata_le",  rdata_le,       e_rd_le);
        end
    end

    // One-cycle request issued at a negedge; returns at the following negedge
    task automatic issue(input logic w, input logic [5:0] a, input logic [1:0] s, input logic [31:0] d);
        req = 1'b1; we = w; addr = a; size = s; wdata = d;
        @(negedge clk);
        req = 1'b0;
    endtask

    task automatic rd_chk(input string nm, input logic [5:0] a, input logic [1:0] s,
                          input logic [31:0] xbe, input logic [31:0] xle, input int lat);
        issue(1'b0, a, s, 32'h0);
        repeat (lat - 1) @(negedge clk);
        chk({nm, "_rvalid_be"}, 32'(rvalid_be), 32'd1);
        chk({nm, "_rvalid_le"}, 32'(rvalid_le), 32'd1);
        chk({nm, "_be"}, rdata_be, xbe);
        chk({nm, "_le"}, rdata_le, xle);
    endtask

    initial begin
        checks = 0; errors = 0; chk_en = 1'b0;
        e_ready = 1'b1; e_rvalid = 1'b0; e_err = 1'b0; e_rd_be = 32'h0; e_rd_le = 32'h0;
        p_on = 1'b0; p_rd = 1'b0; p_n = 0;
        rst = 1'b1; req = 1'b0; we = 1'b0; addr = 6'h0; size = 2'd0; wdata = 32'h0;
        repeat (3) @(negedge clk);
        chk("rst_ready",  32'(ready_be),  32'd1);
        chk("rst_rvalid", 32'(rvalid_be), 32'd0);
        chk("rst_err",    32'(err_le),    32'd0);
        chk("rst_rdata",  rdata_le,       32'h0);
        rst = 1'b0;
        chk_en = 1'b1;

        // Known contents everywhere
        for (int w = 0; w < 16; w++) issue(1'b1, 6'(4 * w), 2'd2, 32'h0);

        issue(1'b1, 6'h00, 2'd2, 32'h11223344);
        rd_chk("byte0", 6'h00, 2'd0, 32'h00000011, 32'h00000044, 1);
        rd_chk("half2", 6'h02, 2'd1, 32'h00003344, 32'h00001122, 1);
        rd_chk("word0", 6'h00, 2'd2, 32'h11223344, 32'h11223344, 1);

        issue(1'b1, 6'h04, 2'd2, 32'hAAAAAAAA);
        issue(1'b1, 6'h05, 2'd0, 32'h0000005A);
        rd_chk("partial", 6'h04, 2'd2, 32'hAA5AAAAA, 32'hAAAA5AAA, 1);

        issue(1'b1, 6'h0C, 2'd2, 32'h12345678);
        rd_chk("b2b", 6'h0C, 2'd2, 32'h12345678, 32'h12345678, 1);

        // Crossing write
        issue(1'b1, 6'h04, 2'd2, 32'h0);
        issue(1'b1, 6'h08, 2'd2, 32'h0);
        issue(1'b1, 6'h06, 2'd2, 32'hAABBCCDD);
        chk("split_ready_be", 32'(ready_be), 32'd0);
        chk("split_ready_le", 32'(ready_le), 32'd0);
        @(negedge clk);
        chk("post_split_ready", 32'(ready_be), 32'd1);
        rd_chk("cross_lo", 6'h04, 2'd2, 32'h0000AABB, 32'hCCDD0000, 1);
        rd_chk("cross_hi", 6'h08, 2'd2, 32'hCCDD0000, 32'h0000AABB, 1);
        rd_chk("cross_rd", 6'h06, 2'd2, 32'hAABBCCDD, 32'hAABBCCDD, 2);

        // Request held during SPLIT is ignored
        req = 1'b1; we = 1'b0; addr = 6'h06; size = 2'd2; wdata = 32'h0;
        @(negedge clk);
        we = 1'b1; addr = 6'h08; size = 2'd0; wdata = 32'h000000FF;
        @(negedge clk);
        req = 1'b0;
        chk("held_rvalid", 32'(rvalid_be), 32'd1);
        chk("held_rdata",  rdata_le, 32'hAABBCCDD);
        rd_chk("ignored", 6'h08, 2'd0, 32'h000000CC, 32'h000000BB, 1);

        // Wrap from the top word to word 0
        issue(1'b1, 6'h3F, 2'd1, 32'h0000BEEF);
        @(negedge clk);
        rd_chk("wrap_top", 6'h3F, 2'd0, 32'h000000BE, 32'h000000EF, 1);
        rd_chk("wrap_b0",  6'h00, 2'd0, 32'h000000EF, 32'h000000BE, 1);
        rd_chk("wrap_rd",  6'h3F, 2'd1, 32'h0000BEEF, 32'h0000BEEF, 2);

        // Invalid size
        issue(1'b1, 6'h00, 2'd3, 32'hFFFFFFFF);
        chk("inv_err_be",  32'(err_be),    32'd1);
        chk("inv_err_le",  32'(err_le),    32'd1);
        chk("inv_rvalid",  32'(rvalid_be), 32'd0);
        rd_chk("inv_mem", 6'h00, 2'd2, 32'hEF223344, 32'h112233BE, 1);

        // Reset during a crossing write
        issue(1'b1, 6'h02, 2'd2, 32'h01020304);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rstw_ready",  32'(ready_be),  32'd1);
        chk("rstw_rvalid", 32'(rvalid_le), 32'd0);
        chk("rstw_err",    32'(err_be),    32'd0);
        rd_chk("rstw_w0", 6'h00, 2'd2, 32'hEF220102, 32'h030433BE, 1);
        rd_chk("rstw_w1", 6'h04, 2'd2, 32'h0000AABB, 32'hCCDD0000, 1);

        // Reset during a crossing read
        issue(1'b0, 6'h06, 2'd2, 32'h0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rstr_rvalid_be", 32'(rvalid_be), 32'd0);
        chk("rstr_rvalid_le", 32'(rvalid_le), 32'd0);
        chk("rstr_rdata",     rdata_be,       32'h0);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/endian_mem_ctrl.md
# endian_mem_ctrl

Parametrised byte-addressable data memory. It succeeds the fixed 32-bit big-endian word memory with configurable word width, depth and byte order, and with byte, halfword, word and doubleword accesses at any byte address. Storage is banked: one byte lane per bank, all banks sharing one word index. An access that crosses a word boundary is split into two cycles by a small FSM. The block sits between the datapath load/store unit and on-chip RAM, behind a ready/valid request handshake.

## Interface
- WORD_BYTES, 4, bytes per word (power of two, 2..8); data width DW = 8*WORD_BYTES
- WORD_ADDR_W, 16, word-index bits; depth = 2**WORD_ADDR_W words
- BIG_ENDIAN, 1, 1: lowest byte address is most significant byte of an access; 0: least significant
- Byte address width BA_W = WORD_ADDR_W + log2(WORD_BYTES)
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  synchronous, active-high reset
- req  in  1  access request; accepted on a cycle with req && ready
- we  in  1  1 = write, 0 = read; sampled with req
- addr  in  BA_W  byte address of the first byte of the access
- size  in  2  access size; 2**size bytes
- wdata  in  DW  write data, right-justified; unused upper bits ignored
- ready  out  1  block can accept a request this cycle
- rvalid  out  1  one-cycle pulse; rdata valid
- rdata  out  DW  read data, right-justified, zero-extended
- err  out  1  one-cycle pulse; the request was rejected

## Operation
- Access bytes N = 2**size. If N > WORD_BYTES, the request is accepted, but there is no memory access and no rvalid; err pulses.
- Byte k of the access (k = 0..N-1) is at byte address addr+k.
  - BIG_ENDIAN=1: byte k maps to data bits [8*(N-1-k)+7 : 8*(N-1-k)].
  - BIG_ENDIAN=0: byte k maps to bits [8*k+7 : 8*k].
- Bank = byte address mod WORD_BYTES. Word index = byte address / WORD_BYTES.
- An access is crossing if (addr mod WORD_BYTES) + N > WORD_BYTES. The word index wraps modulo depth, so the top word is followed by word 0.
- FSM states:
  - IDLE: ready=1.
    - Non-crossing request: all bytes are accessed this cycle; stay in IDLE.
    - Crossing request: access the bytes in the first word; latch we, the remaining byte count, the next word index and, for writes, the remaining wdata bytes; go to SPLIT.
    - Invalid size: err, stay in IDLE.
  - SPLIT: ready=0. Access the remaining bytes, starting at bank 0 of the next word. For reads, merge them with the first-half bytes held in a capture register. Return to IDLE.
- Writes update only the addressed banks; all other bytes keep their values.
- Reads of unaddressed lanes are not visible; rdata bits [DW-1:8N] are 0.
- Memory contents are not reset and not initialised.

## Timing
- Reset values: ready=1, rvalid=0, rdata=0, err=0, FSM=IDLE. Memory is untouched.
- Non-crossing write accepted in cycle T: the data is in memory at the edge ending T.
- Non-crossing read accepted in T: rvalid and rdata are valid in T+1.
- Crossing access accepted in T:
  - SPLIT occupies T+1, with ready=0; any req in T+1 is ignored.
  - A crossing write completes at the edge ending T+1.
  - A crossing read: rvalid in T+2.
  - Next accept is possible in T+2.
- Back-to-back accepts every cycle are allowed for non-crossing accesses. A read of an address written in the previous cycle returns the new data.
- rdata holds its last value when rvalid=0.
- err is asserted in T+1 for an invalid request accepted in T.
- rst=1 in any cycle, including the SPLIT cycle, wins over everything else:
  - FSM goes to IDLE, and outputs take their reset values next cycle.
  - An abandoned crossing write leaves its first half written and its second half not written.
  - An abandoned crossing read produces no rvalid.

## Test plan
- BIG_ENDIAN=1, WORD_BYTES=4:
  - write word 0x11223344 at addr 0x0 -> byte read at 0x0 returns 0x00000011;
  - halfword read at 0x2 returns 0x00003344;
  - each rvalid arrives one cycle after acceptance.
- BIG_ENDIAN=0, same word write -> byte read at 0x0 returns 0x44; word read at 0x0 returns 0x11223344.
- Partial write: word 0xAAAAAAAA at 0x4, then byte write 0x5A at 0x5 -> word read at 0x4 returns 0xAA5AAAAA for BE, 0xAAAA5AAA for LE.
- Crossing, BE:
  - zero words 1–2, then write word 0xAABBCCDD at 0x6 -> ready=0 for one cycle;
  - word read at 0x4 returns 0x0000AABB;
  - word read at 0x8 returns 0xCCDD0000;
  - word read at 0x6 returns 0xAABBCCDD with rvalid two cycles after acceptance.
- Wrap-around and invalid size:
  - halfword write 0xBEEF at the last byte address -> 0xBE at the top byte, 0xEF at byte 0 (BE);
  - size=3 with WORD_BYTES=4 -> err pulse in T+1, no rvalid, memory unchanged.
- Reset mid-split: crossing write 0x01020304 at 0x2 (BE), rst=1 in the SPLIT cycle -> bytes 2–3 = 0x01,0x02, bytes 4–5 unchanged; ready=1, rvalid=0, err=0 after reset.
